// File: rtl/rx_uart.sv
// 8N1 UART receiver with 16x oversampling, centre sampling and break handling.
// Received words are qualified by a one-cycle o_rx_done strobe.
module rx_uart #(
  parameter int unsigned NB_BITS    = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned SB_TICK    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rate,
  input  logic               i_rx,
  output logic [NB_BITS-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err
);

  localparam int unsigned TickMax = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned TW      = (TickMax > 1) ? $clog2(TickMax) : 1;
  localparam int unsigned BW      = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;

  localparam logic [TW-1:0] HalfLast = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BitLast  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] StopLast = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] WordLast = BW'(NB_BITS - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  logic               rx_meta, rx_s;
  logic [2:0]         state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_BITS-1:0] shift_q, shift_d;
  logic [NB_BITS-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          tick_d  = '0;
        end
      end
      StStart: begin
        if (i_rate) begin
          if (tick_q == HalfLast) begin
            if (!rx_s) begin
              state_d = StData;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StData: begin
        if (i_rate) begin
          if (tick_q == BitLast) begin
            shift_d = {rx_s, shift_q[NB_BITS-1:1]};
            tick_d  = '0;
            if (bit_q == WordLast) begin
              state_d = StStop;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (i_rate) begin
          if (tick_q == StopLast) begin
            if (rx_s) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              err_d   = 1'b1;
              state_d = StBreak;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StBreak: begin
        // Wait for the line to recover so a held-low line reports only once.
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_rx_uart.sv
// Directed self-checking bench for rx_uart: nominal, glitch, break, back-to-back,
// sparse-tick and mid-frame-reset scenarios.
module tb_rx_uart;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rate = 1'b1;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;

  int checks = 0;
  int errors = 0;

  int rate_div = 1;
  int div_cnt  = 0;

  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         wide_cnt = 0;
  int         both_cnt = 0;
  logic       done_prev = 1'b0;
  logic [7:0] got_q[$];

  rx_uart #(
    .NB_BITS    (8),
    .OVERSAMPLE (16),
    .SB_TICK    (16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rate      (i_rate),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  // Tick enable: one pulse every rate_div clocks, changed just after the edge.
  always begin
    @(posedge i_clk);
    #1;
    div_cnt = (div_cnt + 1 >= rate_div) ? 0 : div_cnt + 1;
    i_rate  = (div_cnt == 0);
  end

  always @(negedge i_clk) begin
    if (o_rx_done) begin
      done_cnt++;
      got_q.push_back(o_data);
      if (done_prev) wide_cnt++;
    end
    if (o_frame_err) err_cnt++;
    if (o_rx_done && o_frame_err) both_cnt++;
    done_prev = o_rx_done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int cpb);
    i_rx = 1'b0;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      i_rx = data[i];
      tick(cpb);
    end
    i_rx = stop;
    tick(cpb);
  endtask

  initial begin
    tick(3);
    check("reset_data", {24'h0, o_data}, 32'h00);
    check("reset_done", {31'h0, o_rx_done}, 32'h0);
    check("reset_err", {31'h0, o_frame_err}, 32'h0);
    i_rst = 1'b0;
    tick(20);

    // Nominal frame
    send_frame(8'h53, 1'b1, 16);
    tick(20);
    check("nominal_count", done_cnt, 1);
    check("nominal_data", {24'h0, o_data}, 32'h53);
    check("nominal_q0", {24'h0, got_q[0]}, 32'h53);
    check("nominal_err", err_cnt, 0);

    // Glitch shorter than half a bit
    i_rx = 1'b0;
    tick(4);
    i_rx = 1'b1;
    tick(40);
    check("glitch_count", done_cnt, 1);
    check("glitch_data", {24'h0, o_data}, 32'h53);
    check("glitch_err", err_cnt, 0);

    // Frame error followed by a held-low break
    send_frame(8'hA5, 1'b0, 16);
    tick(100);
    i_rx = 1'b1;
    tick(40);
    check("break_err", err_cnt, 1);
    check("break_count", done_cnt, 1);
    check("break_data", {24'h0, o_data}, 32'h53);
    send_frame(8'h3C, 1'b1, 16);
    tick(20);
    check("after_break_count", done_cnt, 2);
    check("after_break_data", {24'h0, got_q[1]}, 32'h3C);
    check("after_break_err", err_cnt, 1);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 16);
    send_frame(8'hFF, 1'b1, 16);
    send_frame(8'h81, 1'b1, 16);
    tick(20);
    check("b2b_count", done_cnt, 5);
    check("b2b_q2", {24'h0, got_q[2]}, 32'h00);
    check("b2b_q3", {24'h0, got_q[3]}, 32'hFF);
    check("b2b_q4", {24'h0, got_q[4]}, 32'h81);

    // Sparse ticks: one per 4 clocks, 64 clocks per bit
    rate_div = 4;
    tick(8);
    send_frame(8'hC3, 1'b1, 64);
    tick(40);
    check("sparse_count", done_cnt, 6);
    check("sparse_data", {24'h0, o_data}, 32'hC3);
    rate_div = 1;
    tick(8);

    // Reset during data bit 3, then abandon the frame
    i_rx = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      i_rx = 8'h5A >> i;
      tick(16);
    end
    i_rx = 1'b1;
    tick(8);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    check("midreset_data", {24'h0, o_data}, 32'h00);
    check("midreset_done", {31'h0, o_rx_done}, 32'h0);
    check("midreset_err", {31'h0, o_frame_err}, 32'h0);
    tick(200);
    check("midreset_count", done_cnt, 6);
    check("midreset_errcnt", err_cnt, 1);
    send_frame(8'h5A, 1'b1, 16);
    tick(20);
    check("post_reset_count", done_cnt, 7);
    check("post_reset_data", {24'h0, o_data}, 32'h5A);

    check("done_width", wide_cnt, 0);
    check("done_err_overlap", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
